inst_fetch_ctrl: RTL and testbench
==================================

// Module: inst_fetch_ctrl
// PURPOSE
//  IF-stage fetch controller: producer feeding the IF/ID pipeline register.
//  Takes the current PC from pc_reg and fetches it over the SRAM-like instruction
//  port (req/addr_ok/data_ok). Buffers the returned word and presents if_pc,
//  if_pc_plus_4, if_exccode, if_inst and if_inst_data_ok until IF/ID accepts it.
//  Requests stalls while a fetch is outstanding. Discards responses made stale by a flush.
// PARAMETERS
//  ADDR_W   32   instruction address width (matches `INST_ADDR_BUS)
//  EXC_W    5    exception code width (matches `EXC_CODE_BUS)
// PORTS
//  cpu_clk_50M      in   1       clock
//  cpu_rst_n        in   1       reset: asynchronous, active-low
//  pc               in   ADDR_W  fetch address from pc_reg; stable while stall[0]==STOP
//  stall            in   `STALL_BUS  stall vector; stall[1]==STOP holds IF
//  flush            in   1       exception/eret flush; pc carries the redirect next cycle
//  inst_req         out  1       SRAM-like request
//  inst_wr          out  1       tied 0
//  inst_size        out  2       tied 2'b10 (word)
//  inst_addr        out  ADDR_W  request address = pc
//  inst_wdata       out  32      tied 0
//  inst_addr_ok     in   1       address accepted this cycle
//  inst_data_ok     in   1       read data valid this cycle
//  inst_rdata       in   32      read data
//  if_pc            out  ADDR_W  PC of the presented instruction
//  if_pc_plus_4     out  ADDR_W  if_pc + 4 (mod 2^32)
//  if_exccode       out  EXC_W   `EXC_NONE, or `EXC_ADEL on a misaligned PC
//  if_inst          out  32      fetched instruction (0 on exception)
//  if_inst_data_ok  out  1       presented instruction valid
//  fetch_stall_req  out  1       to stall ctrl: IF has no valid instruction for pc
// BEHAVIOUR
//  Reset (async): state=IDLE, cancel=0. All outputs 0, except if_exccode=`EXC_NONE.
//  States: IDLE, REQ, WAIT, HOLD, DISCARD.
//  inst_req = (IDLE & ~flush & pc[1:0]==0) | REQ.
//    Address is held constant while req is high.
//  IDLE:
//    pc misaligned & ~flush -> HOLD. Buffer pc, `EXC_ADEL, inst=0; no bus request.
//    Aligned & ~flush: addr_ok -> WAIT; else -> REQ.
//  REQ:
//    addr_ok -> WAIT, or DISCARD if cancel. Req is never withdrawn before addr_ok.
//  WAIT:
//    data_ok & ~flush -> HOLD; capture rdata, pc, `EXC_NONE.
//    flush & ~data_ok -> DISCARD.
//    flush & data_ok -> IDLE (word dropped).
//  DISCARD:
//    data_ok -> IDLE; word dropped and never presented.
//  HOLD:
//    if_inst_data_ok=1 and outputs driven from the buffer.
//    flush -> IDLE.
//    Edge with stall[1]==NOSTOP -> IDLE; IF/ID sampled it and pc advances.
//  cancel: set by flush in REQ; cleared when leaving REQ.
//    A flush in REQ does NOT deassert req.
//  fetch_stall_req = ~(HOLD) & ~flush. Combinational.
//  Outside HOLD: if_* outputs are 0 / `EXC_NONE and if_inst_data_ok=0.
//  Latency: pc valid -> if_inst_data_ok is >= 2 cycles.
//    Minimum: addr_ok in the issue cycle, data_ok the next cycle; registered into HOLD.
//  Simultaneous events:
//    flush has priority over addr_ok/data_ok capture.
//    data_ok with flush in WAIT goes straight to IDLE.
//  Only one request is outstanding, so data_ok outside WAIT/DISCARD is ignored.
//  Reset mid-transaction: state returns to IDLE.
//    The bus slave is reset by the same cpu_rst_n, so no stale data_ok follows.
// STRUCTURE
//  Uses `EXC_NONE, `EXC_ADEL, `STOP/`NOSTOP and bus widths from defines.v.
//  Add state encodings `IF_IDLE .. `IF_DISCARD (3 bits) to defines.v.
//  No sub-module: one FSM plus a 3-word buffer (pc, exccode, inst).
// TESTING
//  1. pc=0xBFC00000, addr_ok same cycle, data_ok next cycle, rdata=0x24080001
//     -> HOLD on the next edge; if_inst=0x24080001, if_pc_plus_4=0xBFC00004,
//        fetch_stall_req=0.
//  2. addr_ok delayed 3 cycles
//     -> inst_req high with inst_addr stable for all 4 cycles; fetch_stall_req=1 throughout.
//  3. HOLD with stall[1]=STOP for 5 cycles
//     -> outputs unchanged. Release -> IDLE next edge; next pc=0xBFC00004 is issued.
//  4. flush in WAIT, data_ok 2 cycles later with 0xDEADBEEF
//     -> DISCARD; 0xDEADBEEF is never presented.
//        Then pc=0xBFC00380 is fetched normally.
//  5. flush in REQ (req held), addr_ok next cycle, then data_ok
//     -> DISCARD -> IDLE; no if_inst_data_ok pulse.
//  6. pc=0xBFC00002
//     -> no inst_req; HOLD with if_exccode=`EXC_ADEL, if_inst=0, if_pc=0xBFC00002.
//     Async reset asserted mid-WAIT -> all outputs cleared immediately.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the IF-stage fetch controller.
// Exception codes follow the MIPS Cause.ExcCode layout; EXC_NONE is an out-of-range marker.
package inst_fetch_ctrl_pkg;

    localparam int unsigned EXC_CODE_W = 5;
    localparam int unsigned STALL_W    = 6;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [EXC_CODE_W-1:0] EXC_NONE = 5'h10;
    localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'h04;

    typedef enum logic [2:0] {
        IfIdle    = 3'd0,
        IfReq     = 3'd1,
        IfWait    = 3'd2,
        IfHold    = 3'd3,
        IfDiscard = 3'd4
    } if_state_e;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch controller: issues one SRAM-like read per PC, buffers the word and
// presents it to IF/ID until accepted. Responses made stale by a flush are dropped.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned EXC_W  = EXC_CODE_W
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    output logic               inst_req,
    output logic               inst_wr,
    output logic [1:0]         inst_size,
    output logic [ADDR_W-1:0]  inst_addr,
    output logic [31:0]        inst_wdata,
    input  logic               inst_addr_ok,
    input  logic               inst_data_ok,
    input  logic [31:0]        inst_rdata,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus_4,
    output logic [EXC_W-1:0]   if_exccode,
    output logic [31:0]        if_inst,
    output logic               if_inst_data_ok,
    output logic               fetch_stall_req
);

    if_state_e state;
    logic      cancel;
    logic      pc_aligned;
    logic      unused_stall;

    assign pc_aligned   = (pc[1:0] == 2'b00);
    assign unused_stall = ^{stall[STALL_W-1:2], stall[0]};

    assign inst_req        = ((state == IfIdle) && !flush && pc_aligned) || (state == IfReq);
    assign inst_wr         = 1'b0;
    assign inst_size       = 2'b10;
    assign inst_addr       = pc;
    assign inst_wdata      = 32'h0;
    assign fetch_stall_req = (state != IfHold) && !flush;

    // The buffer doubles as the registered IF outputs: loaded on entry to HOLD, cleared on exit.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state           <= IfIdle;
            cancel          <= 1'b0;
            if_pc           <= '0;
            if_pc_plus_4    <= '0;
            if_exccode      <= EXC_W'(EXC_NONE);
            if_inst         <= 32'h0;
            if_inst_data_ok <= 1'b0;
        end else begin
            unique case (state)
                IfIdle: begin
                    if (!flush) begin
                        if (!pc_aligned) begin
                            state           <= IfHold;
                            if_pc           <= pc;
                            if_pc_plus_4    <= pc + ADDR_W'(4);
                            if_exccode      <= EXC_W'(EXC_ADEL);
                            if_inst         <= 32'h0;
                            if_inst_data_ok <= 1'b1;
                        end else if (inst_addr_ok) begin
                            state <= IfWait;
                        end else begin
                            state <= IfReq;
                        end
                    end
                end
                IfReq: begin
                    // Request stays up after a flush; the eventual response is thrown away.
                    if (inst_addr_ok) begin
                        state  <= (cancel || flush) ? IfDiscard : IfWait;
                        cancel <= 1'b0;
                    end else if (flush) begin
                        cancel <= 1'b1;
                    end
                end
                IfWait: begin
                    if (flush) begin
                        state <= inst_data_ok ? IfIdle : IfDiscard;
                    end else if (inst_data_ok) begin
                        state           <= IfHold;
                        if_pc           <= pc;
                        if_pc_plus_4    <= pc + ADDR_W'(4);
                        if_exccode      <= EXC_W'(EXC_NONE);
                        if_inst         <= inst_rdata;
                        if_inst_data_ok <= 1'b1;
                    end
                end
                IfDiscard: begin
                    if (inst_data_ok) begin
                        state <= IfIdle;
                    end
                end
                IfHold: begin
                    if (flush || (stall[1] == NOSTOP)) begin
                        state           <= IfIdle;
                        if_pc           <= '0;
                        if_pc_plus_4    <= '0;
                        if_exccode      <= EXC_W'(EXC_NONE);
                        if_inst         <= 32'h0;
                        if_inst_data_ok <= 1'b0;
                    end
                end
                default: begin
                    state  <= IfIdle;
                    cancel <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed and randomized bench for inst_fetch_ctrl; the bench plays the instruction
// bus slave and predicts the presented instruction from the fetch transaction alone.
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    logic               cpu_clk_50M = 1'b0;
    logic               cpu_rst_n;
    logic [31:0]        pc;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               inst_req;
    logic               inst_wr;
    logic [1:0]         inst_size;
    logic [31:0]        inst_addr;
    logic [31:0]        inst_wdata;
    logic               inst_addr_ok;
    logic               inst_data_ok;
    logic [31:0]        inst_rdata;
    logic [31:0]        if_pc;
    logic [31:0]        if_pc_plus_4;
    logic [4:0]         if_exccode;
    logic [31:0]        if_inst;
    logic               if_inst_data_ok;
    logic               fetch_stall_req;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch_ctrl #(
        .ADDR_W(32),
        .EXC_W (5)
    ) dut (
        .cpu_clk_50M    (cpu_clk_50M),
        .cpu_rst_n      (cpu_rst_n),
        .pc             (pc),
        .stall          (stall),
        .flush          (flush),
        .inst_req       (inst_req),
        .inst_wr        (inst_wr),
        .inst_size      (inst_size),
        .inst_addr      (inst_addr),
        .inst_wdata     (inst_wdata),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .if_pc          (if_pc),
        .if_pc_plus_4   (if_pc_plus_4),
        .if_exccode     (if_exccode),
        .if_inst        (if_inst),
        .if_inst_data_ok(if_inst_data_ok),
        .fetch_stall_req(fetch_stall_req)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk1({tag, "_valid"}, if_inst_data_ok, 1'b0);
        chk({tag, "_inst"}, if_inst, 32'h0);
        chk({tag, "_pc"}, if_pc, 32'h0);
        chk({tag, "_pc4"}, if_pc_plus_4, 32'h0);
        chk({tag, "_exc"}, 32'(if_exccode), 32'(EXC_NONE));
    endtask

    // Transaction-level model: what IF/ID should see for a fetch of address a returning rd.
    function automatic logic [31:0] model_inst(input logic [31:0] a, input logic [31:0] rd);
        return (a[1:0] == 2'b00) ? rd : 32'h0;
    endfunction

    function automatic logic [4:0] model_exc(input logic [31:0] a);
        return (a[1:0] == 2'b00) ? EXC_NONE : EXC_ADEL;
    endfunction

    // Full fetch: addr_ok after ad waiting cycles, data_ok dd cycles later, presented
    // instruction held for 'hold' cycles by stall[1]=STOP (optionally with stray data_ok).
    task automatic do_fetch(input logic [31:0] a, input int ad, input int dd,
                            input logic [31:0] rd, input int hold, input bit stray);
        logic [31:0] e_inst;
        logic [4:0]  e_exc;
        pc           = a;
        flush        = 1'b0;
        stall        = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        if (a[1:0] == 2'b00) begin
            for (int i = 0; i <= ad; i++) begin
                inst_addr_ok = (i == ad);
                @(negedge cpu_clk_50M);
                chk1("issue_req", inst_req, 1'b1);
                chk("issue_addr", inst_addr, a);
                chk1("issue_stall_req", fetch_stall_req, 1'b1);
                chk1("issue_valid", if_inst_data_ok, 1'b0);
                tick();
            end
            inst_addr_ok = 1'b0;
            for (int i = 1; i <= dd; i++) begin
                inst_data_ok = (i == dd);
                inst_rdata   = (i == dd) ? rd : $urandom;
                @(negedge cpu_clk_50M);
                chk1("wait_req", inst_req, 1'b0);
                chk1("wait_stall_req", fetch_stall_req, 1'b1);
                chk1("wait_valid", if_inst_data_ok, 1'b0);
                tick();
            end
            inst_data_ok = 1'b0;
        end else begin
            @(negedge cpu_clk_50M);
            chk1("misal_req", inst_req, 1'b0);
            chk1("misal_stall_req", fetch_stall_req, 1'b1);
            tick();
        end
        e_inst = model_inst(a, rd);
        e_exc  = model_exc(a);
        for (int i = 0; i <= hold; i++) begin
            stall        = (i == hold) ? STALL_W'(0) : STALL_W'(3);
            inst_data_ok = stray && (i < hold);
            inst_rdata   = $urandom;
            @(negedge cpu_clk_50M);
            chk1("hold_valid", if_inst_data_ok, 1'b1);
            chk("hold_inst", if_inst, e_inst);
            chk("hold_pc", if_pc, a);
            chk("hold_pc4", if_pc_plus_4, a + 32'd4);
            chk("hold_exc", 32'(if_exccode), 32'(e_exc));
            chk1("hold_stall_req", fetch_stall_req, 1'b0);
            chk1("hold_req", inst_req, 1'b0);
            tick();
        end
        inst_data_ok = 1'b0;
        stall        = '0;
        chk1("release_valid", if_inst_data_ok, 1'b0);
        chk("release_inst", if_inst, 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        cpu_rst_n    = 1'b0;
        pc           = 32'hBFC0_0000;
        stall        = '0;
        flush        = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;

        tick();
        chk_empty("reset");
        chk1("reset_wr", inst_wr, 1'b0);
        chk("reset_size", 32'(inst_size), 32'd2);
        chk("reset_wdata", inst_wdata, 32'h0);
        tick();
        cpu_rst_n = 1'b1;

        // Minimum latency, then a 5-cycle stall hold with stray data_ok.
        do_fetch(32'hBFC0_0000, 0, 1, 32'h2408_0001, 5, 1'b1);
        // addr_ok delayed 3 cycles; next sequential pc is issued straight after release.
        do_fetch(32'hBFC0_0004, 3, 1, 32'h1234_5678, 0, 1'b0);

        // Flush while waiting for data; the stale word must never appear.
        pc = 32'hBFC0_0010; inst_addr_ok = 1'b1;
        @(negedge cpu_clk_50M); chk1("fw_req", inst_req, 1'b1);
        tick();
        inst_addr_ok = 1'b0; flush = 1'b1;
        @(negedge cpu_clk_50M);
        chk1("fw_stall_req", fetch_stall_req, 1'b0);
        chk1("fw_req_flush", inst_req, 1'b0);
        tick();
        flush = 1'b0; pc = 32'hBFC0_0380;
        @(negedge cpu_clk_50M);
        chk1("fw_disc_req", inst_req, 1'b0);
        chk1("fw_disc_stall_req", fetch_stall_req, 1'b1);
        chk1("fw_disc_valid", if_inst_data_ok, 1'b0);
        tick();
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        @(negedge cpu_clk_50M);
        chk1("fw_drop_valid", if_inst_data_ok, 1'b0);
        tick();
        inst_data_ok = 1'b0;
        chk1("fw_after_valid", if_inst_data_ok, 1'b0);
        chk("fw_after_inst", if_inst, 32'h0);
        do_fetch(32'hBFC0_0380, 1, 1, 32'h0000_0000, 1, 1'b0);

        // Flush in REQ: request is held, addr_ok arrives later, response dropped.
        pc = 32'hBFC0_0020;
        @(negedge cpu_clk_50M); chk1("fr_req0", inst_req, 1'b1);
        tick();
        flush = 1'b1;
        @(negedge cpu_clk_50M);
        chk1("fr_req_flush", inst_req, 1'b1);
        chk("fr_addr_flush", inst_addr, 32'hBFC0_0020);
        chk1("fr_stall_req", fetch_stall_req, 1'b0);
        tick();
        flush = 1'b0; inst_addr_ok = 1'b1;
        @(negedge cpu_clk_50M); chk1("fr_req_held", inst_req, 1'b1);
        tick();
        inst_addr_ok = 1'b0;
        @(negedge cpu_clk_50M); chk1("fr_disc_req", inst_req, 1'b0);
        tick();
        inst_data_ok = 1'b1; inst_rdata = 32'hCAFE_F00D;
        @(negedge cpu_clk_50M); chk1("fr_drop_valid", if_inst_data_ok, 1'b0);
        tick();
        inst_data_ok = 1'b0;
        chk1("fr_after_valid", if_inst_data_ok, 1'b0);
        do_fetch(32'hBFC0_0020, 0, 2, 32'h0A0B_0C0D, 0, 1'b0);

        // Flush coinciding with addr_ok in REQ still discards.
        pc = 32'hBFC0_0030;
        tick();
        flush = 1'b1; inst_addr_ok = 1'b1;
        tick();
        flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222;
        tick();
        inst_data_ok = 1'b0;
        chk1("fra_valid", if_inst_data_ok, 1'b0);
        do_fetch(32'hBFC0_0030, 0, 1, 32'h3333_4444, 0, 1'b0);

        // Flush with data_ok in WAIT goes straight to IDLE (do_fetch expects req at once).
        pc = 32'hBFC0_0040; inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; flush = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h5555_6666;
        tick();
        flush = 1'b0; inst_data_ok = 1'b0;
        chk1("fwd_valid", if_inst_data_ok, 1'b0);
        do_fetch(32'hBFC0_0040, 0, 1, 32'h7777_8888, 0, 1'b0);

        // Flush while holding drops the presented instruction.
        pc = 32'hBFC0_0050; inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h9999_AAAA;
        tick();
        inst_data_ok = 1'b0; stall = STALL_W'(3); flush = 1'b1;
        @(negedge cpu_clk_50M);
        chk1("fh_valid", if_inst_data_ok, 1'b1);
        chk1("fh_stall_req", fetch_stall_req, 1'b0);
        tick();
        flush = 1'b0; stall = '0;
        chk_empty("fh_after");

        // Misaligned PC and wrap-around of pc+4.
        do_fetch(32'hBFC0_0002, 0, 1, 32'hFFFF_FFFF, 2, 1'b1);
        do_fetch(32'hFFFF_FFFC, 2, 2, 32'hABCD_EF01, 0, 1'b0);

        // Async reset mid-WAIT: FSM must be back in IDLE (req at once afterwards).
        pc = 32'hBFC0_0060; inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        #2 cpu_rst_n = 1'b0;
        #1 chk_empty("rst_wait");
        tick();
        cpu_rst_n = 1'b1;
        do_fetch(32'hBFC0_0060, 0, 1, 32'h0F0F_0F0F, 0, 1'b0);

        // Async reset in HOLD clears outputs before the next clock edge.
        pc = 32'hBFC0_0070; inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1357_9BDF;
        tick();
        inst_data_ok = 1'b0; stall = STALL_W'(3);
        chk("rh_pre_inst", if_inst, 32'h1357_9BDF);
        #2 cpu_rst_n = 1'b0;
        #1 chk_empty("rst_hold");
        tick();
        cpu_rst_n = 1'b1; stall = '0;

        for (int n = 0; n < 24; n++) begin
            r = $urandom;
            a = r;
            a[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom,
                     int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
